// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queues.
// Entries carry a register index and its data word.
package wb_pkg;

  localparam int         NUM_REGS  = 8;
  localparam int         DEPTH_DEF = 4;
  localparam logic [3:0] NO_WRITE  = 4'hF;

  typedef struct packed {
    logic [3:0]  dst;
    logic [31:0] val;
  } wb_entry_t;

  // Indices at or above NUM_REGS name no architectural register.
  function automatic logic is_reg(input logic [3:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order entry queue for one write-back channel, with a per-slot view of
// the destination indices so the owner can decode pending registers.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [DEPTH-1:0][3:0] slot_dst_o,
  output logic [DEPTH-1:0]      slot_valid_o
);

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid_q;
  wb_entry_t        mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Guard against overflow/underflow even if the owner misbehaves.
  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i  && (count_q != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
        valid_q[wr_ptr_q]  <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q           <= ptr_inc(rd_ptr_q);
        valid_q[rd_ptr_q]  <= 1'b0;
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign slot_valid_o = valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_dst_o[gi] = mem_q[gi].dst;
    end
  endgenerate

endmodule

// File: rtl/wb_writer.sv
// Dual-channel register-file write-back stage: E and M requests are queued,
// issued one per channel per cycle, with E winning same-register collisions.
module wb_writer
  import wb_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter logic [3:0] NO_WRITE = wb_pkg::NO_WRITE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                e_valid,
  input  logic [3:0]          e_dst,
  input  logic [31:0]         e_val,
  output logic                e_ready,
  input  logic                m_valid,
  input  logic [3:0]          m_dst,
  input  logic [31:0]         m_val,
  output logic                m_ready,
  output logic [3:0]          dstE,
  output logic [31:0]         valE,
  output logic [3:0]          dstM,
  output logic [31:0]         valM,
  output logic [NUM_REGS-1:0] pending,
  output logic                empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             e_head;
  wb_entry_t             m_head;
  logic [CW-1:0]         e_count;
  logic [CW-1:0]         m_count;
  logic [DEPTH-1:0][3:0] e_slot_dst;
  logic [DEPTH-1:0][3:0] m_slot_dst;
  logic [DEPTH-1:0]      e_slot_valid;
  logic [DEPTH-1:0]      m_slot_valid;

  logic e_push;
  logic m_push;
  logic e_pop;
  logic m_pop;
  logic e_nonempty;
  logic m_nonempty;
  logic collision;

  logic [3:0]  dst_e_q;
  logic [31:0] val_e_q;
  logic [3:0]  dst_m_q;
  logic [31:0] val_m_q;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign e_ready = (e_count != CW'(DEPTH));
  assign m_ready = (m_count != CW'(DEPTH));

  // Out-of-range destinations are accepted but silently dropped.
  assign e_push = e_valid && e_ready && is_reg(e_dst);
  assign m_push = m_valid && m_ready && is_reg(m_dst);

  assign e_nonempty = (e_count != '0);
  assign m_nonempty = (m_count != '0);
  assign collision  = e_nonempty && m_nonempty && (e_head.dst == m_head.dst);
  assign e_pop      = e_nonempty;
  assign m_pop      = m_nonempty && !collision;

  wb_fifo #(.DEPTH(DEPTH)) u_e_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (e_push),
    .push_entry_i ('{dst: e_dst, val: e_val}),
    .pop_i        (e_pop),
    .head_o       (e_head),
    .count_o      (e_count),
    .slot_dst_o   (e_slot_dst),
    .slot_valid_o (e_slot_valid)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_m_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (m_push),
    .push_entry_i ('{dst: m_dst, val: m_val}),
    .pop_i        (m_pop),
    .head_o       (m_head),
    .count_o      (m_count),
    .slot_dst_o   (m_slot_dst),
    .slot_valid_o (m_slot_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dst_e_q <= NO_WRITE;
      val_e_q <= '0;
      dst_m_q <= NO_WRITE;
      val_m_q <= '0;
    end else begin
      dst_e_q <= e_pop ? e_head.dst : NO_WRITE;
      val_e_q <= e_pop ? e_head.val : '0;
      dst_m_q <= m_pop ? m_head.dst : NO_WRITE;
      val_m_q <= m_pop ? m_head.val : '0;
    end
  end

  assign dstE = dst_e_q;
  assign valE = val_e_q;
  assign dstM = dst_m_q;
  assign valM = val_m_q;

  // A register is pending while any queued slot in either channel names it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      logic hit;
      always_comb begin
        hit = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if (e_slot_valid[j] && (e_slot_dst[j] == 4'(gi))) hit = 1'b1;
          if (m_slot_valid[j] && (m_slot_dst[j] == 4'(gi))) hit = 1'b1;
        end
      end
      assign pending[gi] = hit;
    end
  endgenerate

  assign empty = !e_nonempty && !m_nonempty;

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: stimulus queues expected issues per port,
// a negedge monitor pops and compares every issued write.
module tb_wb_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_dst = '0;
  logic [31:0] e_val = '0;
  logic        e_ready;
  logic        m_valid = 1'b0;
  logic [3:0]  m_dst = '0;
  logic [31:0] m_val = '0;
  logic        m_ready;
  logic [3:0]  dstE;
  logic [31:0] valE;
  logic [3:0]  dstM;
  logic [31:0] valM;
  logic [7:0]  pending;
  logic        empty;

  always #5 clock = ~clock;

  wb_writer #(.DEPTH(4), .NO_WRITE(4'hF)) dut (
    .clock   (clock),
    .reset   (reset),
    .e_valid (e_valid),
    .e_dst   (e_dst),
    .e_val   (e_val),
    .e_ready (e_ready),
    .m_valid (m_valid),
    .m_dst   (m_dst),
    .m_val   (m_val),
    .m_ready (m_ready),
    .dstE    (dstE),
    .valE    (valE),
    .dstM    (dstM),
    .valM    (valM),
    .pending (pending),
    .empty   (empty)
  );

  int errors = 0;
  int checks = 0;
  int e_acc  = 0;
  int m_acc  = 0;
  logic [35:0] exp_e[$];
  logic [35:0] exp_m[$];
  logic [31:0] rf_img[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Record accepted requests, then advance to just after the next rising edge.
  task automatic cycle();
    if (e_valid && e_ready) begin
      if (e_dst < 4'd8) exp_e.push_back({e_dst, e_val});
      e_acc++;
    end
    if (m_valid && m_ready) begin
      if (m_dst < 4'd8) exp_m.push_back({m_dst, m_val});
      m_acc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    e_valid = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < 40 && (exp_e.size() != 0 || exp_m.size() != 0); i++) cycle();
    @(negedge clock);
    #1;
    chk("drain_e", 64'(exp_e.size()), 64'd0);
    chk("drain_m", 64'(exp_m.size()), 64'd0);
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  always @(negedge clock) begin
    logic [35:0] ex;
    if (dstE !== 4'hF) begin
      if (exp_e.size() == 0) begin
        chk("e_unexpected_issue", {28'd0, dstE, valE}, {28'd0, 4'hF, 32'd0});
      end else begin
        ex = exp_e.pop_front();
        chk("e_issue", {28'd0, dstE, valE}, {28'd0, ex});
      end
      rf_img[dstE[2:0]] = valE;
      $display("E write r%0d = %h", dstE, valE);
    end else begin
      chk("e_idle_val", 64'(valE), 64'd0);
    end
    if (dstM !== 4'hF) begin
      if (exp_m.size() == 0) begin
        chk("m_unexpected_issue", {28'd0, dstM, valM}, {28'd0, 4'hF, 32'd0});
      end else begin
        ex = exp_m.pop_front();
        chk("m_issue", {28'd0, dstM, valM}, {28'd0, ex});
      end
      rf_img[dstM[2:0]] = valM;
      $display("M write r%0d = %h", dstM, valM);
    end else begin
      chk("m_idle_val", 64'(valM), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ei;
    int mi;
    logic [3:0] e_list [8];
    logic [3:0] m_list [8];

    // Reset state.
    #12;
    chk("rst_dstE", 64'(dstE), 64'hF);
    chk("rst_dstM", 64'(dstM), 64'hF);
    chk("rst_valE", 64'(valE), 64'd0);
    chk("rst_valM", 64'(valM), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_e_ready", 64'(e_ready), 64'd1);
    chk("rst_m_ready", 64'(m_ready), 64'd1);
    @(negedge clock);
    #2 reset = 1'b1;

    // Single write, accepted on the first edge after release.
    e_valid = 1'b1; e_dst = 4'd2; e_val = 32'hABCDEF98;
    cycle();
    e_valid = 1'b0;
    chk("single_pending_set", 64'(pending), 64'h04);
    chk("single_no_bypass", 64'(dstE), 64'hF);
    cycle();
    chk("single_dstE", 64'(dstE), 64'd2);
    chk("single_valE", 64'(valE), 64'hABCDEF98);
    chk("single_pending_clr", 64'(pending), 64'd0);
    cycle();
    chk("single_hold_one", 64'(dstE), 64'hF);

    // Five back-to-back E requests issue in order.
    for (int i = 0; i < 5; i++) begin
      e_valid = 1'b1; e_dst = 4'(i); e_val = 32'hF0000000 + 32'(i);
      cycle();
    end
    drain();

    // Same-register collision: E wins, M follows one cycle later.
    e_valid = 1'b1; e_dst = 4'd5; e_val = 32'd1;
    m_valid = 1'b1; m_dst = 4'd5; m_val = 32'd2;
    cycle();
    e_valid = 1'b0; m_valid = 1'b0;
    cycle();
    chk("coll_dstE", 64'(dstE), 64'd5);
    chk("coll_valE", 64'(valE), 64'd1);
    chk("coll_dstM_held", 64'(dstM), 64'hF);
    cycle();
    chk("coll_dstM", 64'(dstM), 64'd5);
    chk("coll_valM", 64'(valM), 64'd2);
    chk("coll_dstE_idle", 64'(dstE), 64'hF);
    drain();

    // Sustained collisions hold M until its queue fills.
    base = m_acc;
    for (int k = 0; k < 7; k++) begin
      e_valid = (k < 6); e_dst = 4'd3; e_val = 32'h100 + 32'(k);
      m_valid = ((m_acc - base) < 5); m_dst = 4'd3; m_val = 32'h200 + 32'(m_acc - base);
      cycle();
      if (k == 3) chk("mfull_ready", 64'(m_ready), 64'd0);
      if (k == 6) begin
        chk("mfull_ready_with_pop", 64'(m_ready), 64'd0);
        chk("mfull_dstM_held", 64'(dstM), 64'hF);
      end
    end
    e_valid = 1'b0;
    for (int t = 0; t < 20 && (m_acc - base) < 5; t++) begin
      m_valid = 1'b1; m_dst = 4'd3; m_val = 32'h200 + 32'(m_acc - base);
      cycle();
    end
    m_valid = 1'b0;
    chk("mfull_fifth_accepted", 64'(m_acc - base), 64'd5);
    drain();

    // Out-of-range destination is consumed and dropped.
    m_valid = 1'b1; m_dst = 4'd9; m_val = 32'hDEADBEEF;
    cycle();
    m_valid = 1'b0;
    chk("discard_ready", 64'(m_ready), 64'd1);
    chk("discard_pending", 64'(pending), 64'd0);
    chk("discard_empty", 64'(empty), 64'd1);
    cycle();
    chk("discard_no_issue", 64'(dstM), 64'hF);

    // Reset in mid-operation with three entries queued.
    e_valid = 1'b1; e_dst = 4'd1; e_val = 32'hA0;
    m_valid = 1'b1; m_dst = 4'd1; m_val = 32'hB0;
    cycle();
    e_val = 32'hA1; m_val = 32'hB1;
    cycle();
    e_valid = 1'b0; m_valid = 1'b0;
    chk("midop_not_empty", 64'(empty), 64'd0);
    chk("midop_pending", 64'(pending), 64'h02);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_dstE", 64'(dstE), 64'hF);
    chk("midrst_dstM", 64'(dstM), 64'hF);
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_e_ready", 64'(e_ready), 64'd1);
    chk("midrst_m_ready", 64'(m_ready), 64'd1);
    exp_e.delete();
    exp_m.delete();
    #1 reset = 1'b1;
    cycle();
    chk("post_rel_dstE", 64'(dstE), 64'hF);
    chk("post_rel_dstM", 64'(dstM), 64'hF);
    cycle();

    // Dual stream with random valid toggling.
    for (int r = 0; r < 8; r++) rf_img[r] = '0;
    for (int i = 0; i < 8; i++) begin
      e_list[i] = 4'(i % 4);
      m_list[i] = 4'(4 + (i % 4));
    end
    ei = e_acc; mi = m_acc;
    for (int t = 0; t < 300 && ((e_acc - ei) < 8 || (m_acc - mi) < 8); t++) begin
      e_valid = ((e_acc - ei) < 8) && ($urandom_range(0, 1) == 1);
      if ((e_acc - ei) < 8) begin
        e_dst = e_list[e_acc - ei]; e_val = 32'h11110000 + 32'(e_acc - ei);
      end
      m_valid = ((m_acc - mi) < 8) && ($urandom_range(0, 1) == 1);
      if ((m_acc - mi) < 8) begin
        m_dst = m_list[m_acc - mi]; m_val = 32'h22220000 + 32'(m_acc - mi);
      end
      cycle();
    end
    chk("dual_e_count", 64'(e_acc - ei), 64'd8);
    chk("dual_m_count", 64'(m_acc - mi), 64'd8);
    drain();
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("rf_img_r%0d", r), 64'(rf_img[r]),
          (r < 4) ? 64'(32'h11110004 + 32'(r)) : 64'(32'h22220004 + 32'(r - 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
